// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a tile of weight rows into a ROWS x COLS systolic array,
// then streams input vectors onto the west edge with a per-row skew of r cycles.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   w_data/w_valid/w_ready      weight-row beats, column c in [c*DATA_W +: DATA_W]
//   x_data/x_valid/x_ready      input vectors, row r in [r*DATA_W +: DATA_W]
//   x_last                      marks the final vector of a tile
//   pe_weight_out/pe_accept_w_out  weight row and accept strobe to the column tops
//   pe_input_out/pe_valid_out/pe_switch_out  skewed west-edge data and strobes
//   tile_done                   one-cycle pulse in the final drain cycle
//   perf_tiles/perf_bubbles     saturating counters, present only when
//                               SYSTOLIC_FEEDER_PERF_EN is defined
module systolic_feeder #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COLS*DATA_W-1:0]   w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [ROWS*DATA_W-1:0]   x_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     x_last,
  output logic [COLS*DATA_W-1:0]   pe_weight_out,
  output logic [COLS-1:0]          pe_accept_w_out,
  output logic [ROWS*DATA_W-1:0]   pe_input_out,
  output logic [ROWS-1:0]          pe_valid_out,
  output logic [ROWS-1:0]          pe_switch_out,
  output logic                     tile_done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [31:0]              perf_tiles,
  output logic [31:0]              perf_bubbles
`endif
);

  localparam int unsigned BEAT_W    = $clog2(ROWS + 1);
  localparam int unsigned DRAIN_LEN = ROWS + COLS - 1;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam int unsigned ENT_W     = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic                      first_q, first_d;
  logic                      w_ready_q, w_ready_d;
  logic                      x_ready_q, x_ready_d;
  logic                      tile_done_q, tile_done_d;
  logic [COLS*DATA_W-1:0]    weight_q, weight_d;
  logic [COLS-1:0]           accept_q, accept_d;

  logic w_hs;
  logic x_hs;

  assign w_hs = w_valid & w_ready_q;
  assign x_hs = x_valid & x_ready_q;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    first_d     = first_q;
    unique case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          beat_d = BEAT_W'(1);
          if (ROWS == 1) begin
            state_d = S_STREAM;
            first_d = 1'b1;
          end else begin
            state_d = S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(ROWS - 1)) begin
            state_d = S_STREAM;
            first_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (x_hs) begin
          first_d = 1'b0;
          if (x_last) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) begin
          state_d = S_IDLE;
          beat_d  = '0;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    w_ready_d   = (state_d == S_IDLE) || (state_d == S_LOAD_W);
    x_ready_d   = (state_d == S_STREAM);
    tile_done_d = (state_d == S_DRAIN) && (drain_d == DRAIN_W'(DRAIN_LEN - 1));
    weight_d    = w_hs ? w_data : '0;
    accept_d    = w_hs ? '1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      drain_q     <= '0;
      first_q     <= 1'b0;
      w_ready_q   <= 1'b1;
      x_ready_q   <= 1'b0;
      tile_done_q <= 1'b0;
      weight_q    <= '0;
      accept_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      first_q     <= first_d;
      w_ready_q   <= w_ready_d;
      x_ready_q   <= x_ready_d;
      tile_done_q <= tile_done_d;
      weight_q    <= weight_d;
      accept_q    <= accept_d;
    end
  end

  // w_ready is held low while reset is asserted and comes up as soon as it releases
  assign w_ready         = w_ready_q & ~rst;
  assign x_ready         = x_ready_q;
  assign tile_done       = tile_done_q;
  assign pe_weight_out   = weight_q;
  assign pe_accept_w_out = accept_q;

  // Per-row skew line of depth r+1; each entry is {switch, valid, data}
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int unsigned DEPTH = r + 1;

    logic [DATA_W-1:0] row_in;
    logic [ENT_W-1:0]  pipe_q [DEPTH];
    logic [ENT_W-1:0]  pipe_d [DEPTH];

    // Bubbles enter the line as all-zero entries
    assign row_in = x_hs ? x_data[r*DATA_W +: DATA_W] : '0;

    always_comb begin
      pipe_d[0] = {x_hs & first_q, x_hs, row_in};
      for (int unsigned k = 1; k < DEPTH; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          pipe_q[k] <= '0;
        end
      end else begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          pipe_q[k] <= pipe_d[k];
        end
      end
    end

    assign pe_input_out[r*DATA_W +: DATA_W] = pipe_q[DEPTH-1][DATA_W-1:0];
    assign pe_valid_out[r]                  = pipe_q[DEPTH-1][DATA_W];
    assign pe_switch_out[r]                 = pipe_q[DEPTH-1][DATA_W+1];
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0] perf_tiles_q, perf_tiles_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Saturating tile and bubble counters
  always_comb begin
    perf_tiles_d   = perf_tiles_q;
    perf_bubbles_d = perf_bubbles_q;
    if (tile_done_q && (perf_tiles_q != '1)) begin
      perf_tiles_d = perf_tiles_q + 32'd1;
    end
    if ((state_q == S_STREAM) && !x_hs && (perf_bubbles_q != '1)) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_tiles_q   <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_tiles_q   <= perf_tiles_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_tiles   = perf_tiles_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder (2x2, 16-bit): directed tile scenarios with literal
// expectations plus a randomized run, all checked every cycle against a schedule-based
// model of when each beat and vector must appear on the array edges.
module tb_systolic_feeder;

  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 2;
  localparam int unsigned DW   = 16;
  localparam int SL            = 64;

  logic                  clk;
  logic                  rst;
  logic [COLS*DW-1:0]    w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [ROWS*DW-1:0]    x_data;
  logic                  x_valid;
  logic                  x_ready;
  logic                  x_last;
  logic [COLS*DW-1:0]    pe_weight_out;
  logic [COLS-1:0]       pe_accept_w_out;
  logic [ROWS*DW-1:0]    pe_input_out;
  logic [ROWS-1:0]       pe_valid_out;
  logic [ROWS-1:0]       pe_switch_out;
  logic                  tile_done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0]           perf_tiles;
  logic [31:0]           perf_bubbles;
`endif

  systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .w_data          (w_data),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .x_data          (x_data),
    .x_valid         (x_valid),
    .x_ready         (x_ready),
    .x_last          (x_last),
    .pe_weight_out   (pe_weight_out),
    .pe_accept_w_out (pe_accept_w_out),
    .pe_input_out    (pe_input_out),
    .pe_valid_out    (pe_valid_out),
    .pe_switch_out   (pe_switch_out),
    .tile_done       (tile_done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .perf_tiles      (perf_tiles),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs per cycle, indexed by cycle number modulo SL
  logic [COLS*DW-1:0] e_w   [SL];
  logic [COLS-1:0]    e_acc [SL];
  logic [ROWS*DW-1:0] e_in  [SL];
  logic [ROWS-1:0]    e_val [SL];
  logic [ROWS-1:0]    e_sw  [SL];
  logic               e_done[SL];

  int cyc       = 0;
  int wbeats    = 0;
  int drain_end = -1;
  bit streaming = 0;
  bit first     = 0;
  bit exp_w     = 1;
  bit exp_x     = 0;
  int m_bub     = 0;
  int m_tiles   = 0;
  bit whs, xhs;
  int s, s2;

  task automatic clear_slot(input int k);
    e_w[k] = '0; e_acc[k] = '0; e_in[k] = '0;
    e_val[k] = '0; e_sw[k] = '0; e_done[k] = 1'b0;
  endtask

  // Model: each accepted item is scheduled onto the cycles where it must be seen
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SL; k++) clear_slot(k);
      wbeats = 0; streaming = 0; first = 0; drain_end = -1;
      exp_w = 1; exp_x = 0; m_bub = 0; m_tiles = 0;
      cyc++;
    end else begin
      whs = w_valid && exp_w;
      xhs = x_valid && exp_x;
      s = cyc % SL;
      if (e_done[s]) m_tiles++;
      if (exp_x && !xhs) m_bub++;
      clear_slot(s);
      cyc++;
      s = cyc % SL;
      if (whs) begin
        e_w[s] = w_data;
        e_acc[s] = '1;
        wbeats++;
        if (wbeats == ROWS) begin
          streaming = 1;
          first = 1;
        end
      end
      if (xhs) begin
        for (int r = 0; r < ROWS; r++) begin
          s2 = (cyc + r) % SL;
          e_in[s2][r*DW +: DW] = x_data[r*DW +: DW];
          e_val[s2][r] = 1'b1;
          e_sw[s2][r]  = first;
        end
        first = 0;
        if (x_last) begin
          streaming = 0;
          drain_end = cyc + ROWS + COLS - 2;
          e_done[drain_end % SL] = 1'b1;
        end
      end
      if (!streaming && wbeats == ROWS && cyc > drain_end) wbeats = 0;
      exp_w = !streaming && (cyc > drain_end) && (wbeats < ROWS);
      exp_x = streaming;
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_w_ready", 64'(w_ready), 64'd0);
      chk("rst_x_ready", 64'(x_ready), 64'd0);
      chk("rst_weight", 64'(pe_weight_out), 64'd0);
      chk("rst_accept", 64'(pe_accept_w_out), 64'd0);
      chk("rst_input", 64'(pe_input_out), 64'd0);
      chk("rst_valid", 64'(pe_valid_out), 64'd0);
      chk("rst_switch", 64'(pe_switch_out), 64'd0);
      chk("rst_done", 64'(tile_done), 64'd0);
    end else begin
      s2 = cyc % SL;
      chk("w_ready", 64'(w_ready), 64'(exp_w));
      chk("x_ready", 64'(x_ready), 64'(exp_x));
      chk("weight", 64'(pe_weight_out), 64'(e_w[s2]));
      chk("accept", 64'(pe_accept_w_out), 64'(e_acc[s2]));
      chk("input", 64'(pe_input_out), 64'(e_in[s2]));
      chk("valid", 64'(pe_valid_out), 64'(e_val[s2]));
      chk("switch", 64'(pe_switch_out), 64'(e_sw[s2]));
      chk("tile_done", 64'(tile_done), 64'(e_done[s2]));
`ifdef SYSTOLIC_FEEDER_PERF_EN
      chk("perf_tiles", 64'(perf_tiles), 64'(m_tiles));
      chk("perf_bubbles", 64'(perf_bubbles), 64'(m_bub));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic put_w(input logic [COLS*DW-1:0] d);
    int n = 0;
    w_data = d;
    w_valid = 1'b1;
    while (!w_ready && n < 50) begin
      tick();
      n++;
    end
    chk("w_ready_wait", 64'(w_ready), 64'd1);
    tick();
    w_valid = 1'b0;
  endtask

  // Leaves x_valid asserted so the caller can send back-to-back vectors
  task automatic put_x(input logic [ROWS*DW-1:0] d, input logic last);
    int n = 0;
    x_data = d;
    x_last = last;
    x_valid = 1'b1;
    while (!x_ready && n < 50) begin
      tick();
      n++;
    end
    chk("x_ready_wait", 64'(x_ready), 64'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    w_data = '0; w_valid = 1'b0;
    x_data = '0; x_valid = 1'b0; x_last = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Weight load: {3,4} then {1,2}
    put_w({16'd4, 16'd3});
    chk("d033_w0", 64'(pe_weight_out), 64'h0004_0003);
    chk("d033_acc0", 64'(pe_accept_w_out), 64'h3);
    chk("d033_xr0", 64'(x_ready), 64'd0);
    put_w({16'd2, 16'd1});
    chk("d033_w1", 64'(pe_weight_out), 64'h0002_0001);
    chk("d033_acc1", 64'(pe_accept_w_out), 64'h3);
    chk("d033_xr1", 64'(x_ready), 64'd1);

    // Back-to-back vectors {5,6} then last {7,8}
    put_x({16'd6, 16'd5}, 1'b0);
    chk("d034_in_t1", 64'(pe_input_out), 64'h0000_0005);
    chk("d034_v_t1", 64'(pe_valid_out), 64'h1);
    chk("d034_sw_t1", 64'(pe_switch_out), 64'h1);
    put_x({16'd8, 16'd7}, 1'b1);
    x_valid = 1'b0; x_last = 1'b0;
    chk("d034_in_t2", 64'(pe_input_out), 64'h0006_0007);
    chk("d034_v_t2", 64'(pe_valid_out), 64'h3);
    chk("d034_sw_t2", 64'(pe_switch_out), 64'h2);
    tick();
    chk("d034_in_t3", 64'(pe_input_out), 64'h0008_0000);
    chk("d034_v_t3", 64'(pe_valid_out), 64'h2);
    chk("d034_sw_t3", 64'(pe_switch_out), 64'h0);
    chk("d034_done_t3", 64'(tile_done), 64'd0);
    tick();
    chk("d034_done_t4", 64'(tile_done), 64'd1);
    tick();
    chk("d034_wr_t5", 64'(w_ready), 64'd1);

    // Single-vector tile {9,10}
    put_w({16'd4, 16'd3});
    put_w({16'd2, 16'd1});
    put_x({16'd10, 16'd9}, 1'b1);
    x_valid = 1'b0; x_last = 1'b0;
    chk("d036_v_t1", 64'(pe_valid_out), 64'h1);
    chk("d036_sw_t1", 64'(pe_switch_out), 64'h1);
    chk("d036_in_t1", 64'(pe_input_out), 64'h0000_0009);
    tick();
    chk("d036_sw_t2", 64'(pe_switch_out), 64'h2);
    chk("d036_in_t2", 64'(pe_input_out), 64'h000a_0000);
    chk("d036_done_t2", 64'(tile_done), 64'd0);
    tick();
    chk("d036_done_t3", 64'(tile_done), 64'd1);
    chk("d036_wr_t3", 64'(w_ready), 64'd0);
    tick();
    chk("d036_wr_t4", 64'(w_ready), 64'd1);

    // One-cycle bubble between two vectors
    do_reset();
    tick();
    put_w({16'd4, 16'd3});
    put_w({16'd2, 16'd1});
    put_x({16'd6, 16'd5}, 1'b0);
    x_valid = 1'b0;
    tick();
    chk("d035_v_bub0", 64'(pe_valid_out), 64'h2);
    chk("d035_in_bub0", 64'(pe_input_out), 64'h0006_0000);
    put_x({16'd8, 16'd7}, 1'b1);
    x_valid = 1'b0; x_last = 1'b0;
    chk("d035_v_bub1", 64'(pe_valid_out), 64'h1);
    chk("d035_sw_bub1", 64'(pe_switch_out), 64'h0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
    chk("d035_perf_bub", 64'(perf_bubbles), 64'd1);
`endif
    tick(); tick(); tick();

    // Reset in the middle of streaming
    put_w({16'd4, 16'd3});
    put_w({16'd2, 16'd1});
    put_x({16'd12, 16'd11}, 1'b0);
    x_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("d037_valid", 64'(pe_valid_out), 64'd0);
    chk("d037_input", 64'(pe_input_out), 64'd0);
    chk("d037_xready", 64'(x_ready), 64'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d037_no_valid", 64'(pe_valid_out), 64'd0);
      chk("d037_no_switch", 64'(pe_switch_out), 64'd0);
    end

    // Next tile after the reset loads normally
    put_w({16'd4, 16'd3});
    put_w({16'd2, 16'd1});
    put_x({16'd10, 16'd9}, 1'b1);
    x_valid = 1'b0; x_last = 1'b0;
    chk("d037_next_v", 64'(pe_valid_out), 64'h1);
    tick(); tick(); tick();

    // Randomized traffic, including handshakes offered while not ready
    for (int i = 0; i < 4000; i++) begin
      w_valid = 1'($urandom_range(0, 1));
      w_data  = $urandom;
      x_valid = ($urandom_range(0, 3) != 0);
      x_data  = $urandom;
      x_last  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        w_valid = 1'b0;
        x_valid = 1'b0;
        do_reset();
      end else begin
        tick();
      end
    end

    w_valid = 1'b0; x_valid = 1'b0; x_last = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter ROWS, default 2, number of array rows fed on the west edge.
REQ-002 Parameter COLS, default 2, number of array columns fed on the north edge.
REQ-003 Parameter DATA_W, default 16, signed fixed-point word width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 w_data  in  COLS*DATA_W  one weight row; column c in bits [c*DATA_W +: DATA_W].
REQ-007 w_valid / w_ready  in / out  1  weight-row handshake; a beat transfers when both are high at a rising edge.
REQ-008 x_data  in  ROWS*DATA_W  one input vector; row r in bits [r*DATA_W +: DATA_W].
REQ-009 x_valid / x_ready  in / out  1  input-vector handshake.
REQ-010 x_last  in  1  qualifies the final input vector of the tile; sampled only on an x handshake.
REQ-011 pe_weight_out  out  COLS*DATA_W  weight driven into the top of each column.
REQ-012 pe_accept_w_out  out  COLS  per-column weight-accept strobe.
REQ-013 pe_input_out  out  ROWS*DATA_W  west-edge input per row.
REQ-014 pe_valid_out / pe_switch_out  out  ROWS  per-row valid and weight-switch strobes.
REQ-015 tile_done  out  1  one-cycle pulse when a tile has fully drained.

Function
REQ-016 FSM states: IDLE, LOAD_W, STREAM, DRAIN; a 2-bit state register drives all outputs.
REQ-017 IDLE: w_ready=1, x_ready=0; a w handshake counts beat 1 and enters LOAD_W (or STREAM if ROWS=1).
REQ-018 LOAD_W: w_ready=1 until ROWS beats total; the ROWS-th handshake enters STREAM on the next cycle.
REQ-019 Weight rows are pushed in arrival order; upstream supplies the bottom array row first.
REQ-020 A w beat accepted at edge t appears on pe_weight_out with pe_accept_w_out all ones during cycle t+1; otherwise pe_weight_out=0 and pe_accept_w_out=0.
REQ-021 STREAM: x_ready=1, w_ready=0; an x handshake accepted at edge t drives row r (pe_input_out, pe_valid_out=1) during cycle t+1+r.
REQ-022 Cycles in STREAM without an x handshake inject a bubble: row 0 gets valid=0 and input=0, skewed identically, so bubbles are legal.
REQ-023 pe_switch_out[r] is asserted only alongside the first accepted vector of each tile, with the same r-cycle skew; it is never asserted for bubbles.
REQ-024 An x handshake with x_last=1 enters DRAIN; a tile may consist of one vector, in which case switch and last coincide.
REQ-025 DRAIN lasts exactly ROWS+COLS-1 cycles, counted from the cycle after the last handshake, so every PE sees its switch before the next weight load; w_ready=0 and x_ready=0 throughout.
REQ-026 tile_done pulses in the final DRAIN cycle; the FSM returns to IDLE on the next cycle.
REQ-027 Data is passed through unmodified; no arithmetic is performed and widths are unchanged.
REQ-028 w_valid or x_valid asserted in a state whose ready is 0 has no effect.

Reset
REQ-029 rst asserted forces IDLE, clears the beat and drain counters and all skew registers, and drives every output to 0 except w_ready=1 after release.
REQ-030 Reset mid-tile discards all in-flight vectors; no partial switch or valid pulse is emitted after release.

Configuration
REQ-031 Macro SYSTOLIC_FEEDER_PERF_EN, when defined, adds outputs perf_tiles (32-bit, +1 per tile_done) and perf_bubbles (32-bit, +1 per STREAM cycle without an x handshake); both saturate and clear on rst.
REQ-032 Without SYSTOLIC_FEEDER_PERF_EN, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-033 2x2: w beats {3,4} then {1,2} -> pe_weight_out {3,4} then {1,2} on consecutive cycles with accept=11; x_ready rises the cycle after the second beat.
REQ-034 2x2: x {5,6} first, x {7,8} last, back-to-back -> row0 carries 5,7 at t+1,t+2; row1 carries 6,8 at t+2,t+3; switch on row0 at t+1 and row1 at t+2 only.
REQ-035 x_valid low for one cycle between the two vectors -> one valid=0 bubble on row0, then on row1 one cycle later; perf_bubbles=1 if enabled.
REQ-036 Single-vector tile {9,10} with x_last=1 -> switch and valid coincide; tile_done exactly 3 cycles after the handshake; w_ready=1 the following cycle.
REQ-037 rst asserted during STREAM after one vector -> all outputs 0 immediately; no further valid or switch pulses; next tile loads normally.
